// File: rtl/id_ex_register.sv
// ID/EX pipeline register: holds decode-stage datapath and control fields for execute,
// with stall/flush handling and a saturating count of inserted bubbles.
module id_ex_register (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        inValid,
  input  logic [31:0] pcIn,
  input  logic [31:0] pcPlus4In,
  input  logic [31:0] readData1In,
  input  logic [31:0] readData2In,
  input  logic [31:0] immExtIn,
  input  logic [4:0]  rs1In,
  input  logic [4:0]  rs2In,
  input  logic [4:0]  rdIn,
  input  logic [2:0]  func3In,
  input  logic [6:0]  func7In,
  input  logic [2:0]  aluControlIn,
  input  logic        regWriteIn,
  input  logic        memWriteIn,
  input  logic        memReadIn,
  input  logic        branchIn,
  input  logic        jumpIn,
  input  logic        aluSrcIn,
  input  logic [1:0]  resultSrcIn,
  output logic [31:0] pcOut,
  output logic [31:0] pcPlus4Out,
  output logic [31:0] readData1Out,
  output logic [31:0] readData2Out,
  output logic [31:0] immExtOut,
  output logic [4:0]  rs1Out,
  output logic [4:0]  rs2Out,
  output logic [4:0]  rdOut,
  output logic [2:0]  func3Out,
  output logic [6:0]  func7Out,
  output logic [2:0]  aluControlOut,
  output logic        regWriteOut,
  output logic        memWriteOut,
  output logic        memReadOut,
  output logic        branchOut,
  output logic        jumpOut,
  output logic        aluSrcOut,
  output logic [1:0]  resultSrcOut,
  output logic        validOut,
  output logic [15:0] bubbleCount
);

  logic bubble_s;
  logic load_s;

  // Decode the per-edge action: flush wins over stall; an invalid load is a bubble.
  always_comb begin
    bubble_s = 1'b0;
    load_s   = 1'b0;
    if (flush) begin
      bubble_s = 1'b1;
    end else if (stall) begin
      bubble_s = 1'b0;
      load_s   = 1'b0;
    end else if (!inValid) begin
      bubble_s = 1'b1;
    end else begin
      load_s = 1'b1;
    end
  end

  // Pipeline payload: cleared on reset or bubble, loaded on a valid advance, otherwise held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bubble_s) begin
      pcOut         <= 32'h0000_0000;
      pcPlus4Out    <= 32'h0000_0000;
      readData1Out  <= 32'h0000_0000;
      readData2Out  <= 32'h0000_0000;
      immExtOut     <= 32'h0000_0000;
      rs1Out        <= 5'd0;
      rs2Out        <= 5'd0;
      rdOut         <= 5'd0;
      func3Out      <= 3'd0;
      func7Out      <= 7'd0;
      aluControlOut <= 3'd0;
      regWriteOut   <= 1'b0;
      memWriteOut   <= 1'b0;
      memReadOut    <= 1'b0;
      branchOut     <= 1'b0;
      jumpOut       <= 1'b0;
      aluSrcOut     <= 1'b0;
      resultSrcOut  <= 2'd0;
      validOut      <= 1'b0;
    end else if (load_s) begin
      pcOut         <= pcIn;
      pcPlus4Out    <= pcPlus4In;
      readData1Out  <= readData1In;
      readData2Out  <= readData2In;
      immExtOut     <= immExtIn;
      rs1Out        <= rs1In;
      rs2Out        <= rs2In;
      rdOut         <= rdIn;
      func3Out      <= func3In;
      func7Out      <= func7In;
      aluControlOut <= aluControlIn;
      regWriteOut   <= regWriteIn;
      memWriteOut   <= memWriteIn;
      memReadOut    <= memReadIn;
      branchOut     <= branchIn;
      jumpOut       <= jumpIn;
      aluSrcOut     <= aluSrcIn;
      resultSrcOut  <= resultSrcIn;
      validOut      <= 1'b1;
    end else begin
      validOut      <= validOut;
    end
  end

  // Bubble counter saturates rather than wrapping; reset itself is not a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubbleCount <= 16'h0000;
    end else if (bubble_s && (bubbleCount != 16'hFFFF)) begin
      bubbleCount <= bubbleCount + 16'h0001;
    end else begin
      bubbleCount <= bubbleCount;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Directed self-checking bench for id_ex_register: load, stall, flush, invalid input,
// counter saturation and asynchronous reset.
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        reset, stall, flush, inValid;
  logic [31:0] pcIn, pcPlus4In, readData1In, readData2In, immExtIn;
  logic [4:0]  rs1In, rs2In, rdIn;
  logic [2:0]  func3In, aluControlIn;
  logic [6:0]  func7In;
  logic        regWriteIn, memWriteIn, memReadIn, branchIn, jumpIn, aluSrcIn;
  logic [1:0]  resultSrcIn;
  logic [31:0] pcOut, pcPlus4Out, readData1Out, readData2Out, immExtOut;
  logic [4:0]  rs1Out, rs2Out, rdOut;
  logic [2:0]  func3Out, aluControlOut;
  logic [6:0]  func7Out;
  logic        regWriteOut, memWriteOut, memReadOut, branchOut, jumpOut, aluSrcOut;
  logic [1:0]  resultSrcOut;
  logic        validOut;
  logic [15:0] bubbleCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_register dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .inValid(inValid),
    .pcIn(pcIn), .pcPlus4In(pcPlus4In), .readData1In(readData1In),
    .readData2In(readData2In), .immExtIn(immExtIn),
    .rs1In(rs1In), .rs2In(rs2In), .rdIn(rdIn),
    .func3In(func3In), .func7In(func7In), .aluControlIn(aluControlIn),
    .regWriteIn(regWriteIn), .memWriteIn(memWriteIn), .memReadIn(memReadIn),
    .branchIn(branchIn), .jumpIn(jumpIn), .aluSrcIn(aluSrcIn), .resultSrcIn(resultSrcIn),
    .pcOut(pcOut), .pcPlus4Out(pcPlus4Out), .readData1Out(readData1Out),
    .readData2Out(readData2Out), .immExtOut(immExtOut),
    .rs1Out(rs1Out), .rs2Out(rs2Out), .rdOut(rdOut),
    .func3Out(func3Out), .func7Out(func7Out), .aluControlOut(aluControlOut),
    .regWriteOut(regWriteOut), .memWriteOut(memWriteOut), .memReadOut(memReadOut),
    .branchOut(branchOut), .jumpOut(jumpOut), .aluSrcOut(aluSrcOut),
    .resultSrcOut(resultSrcOut), .validOut(validOut), .bubbleCount(bubbleCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Concatenation of every Out field so "all zero" / "unchanged" can be checked in one go.
  function automatic logic [255:0] all_outs();
    return {pcOut, pcPlus4Out, readData1Out, readData2Out, immExtOut, rs1Out, rs2Out, rdOut,
            func3Out, func7Out, aluControlOut, regWriteOut, memWriteOut, memReadOut,
            branchOut, jumpOut, aluSrcOut, resultSrcOut, validOut, bubbleCount};
  endfunction

  task automatic chk_zero(input string tag);
    logic [255:0] v;
    v = all_outs();
    checks++;
    assert (v === 256'd0) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=0", tag, v);
    end
  endtask

  task automatic set_load27();
    inValid = 1'b1; pcIn = 32'h0000_0040; pcPlus4In = 32'h0000_0044;
    readData1In = 32'h1111_2222; readData2In = 32'h3333_4444; immExtIn = 32'hFFFF_FFF8;
    rs1In = 5'd3; rs2In = 5'd4; rdIn = 5'd9;
    aluControlIn = 3'b010; func3In = 3'b101; func7In = 7'b0100000;
    regWriteIn = 1'b1; memWriteIn = 1'b0; memReadIn = 1'b1; branchIn = 1'b0;
    jumpIn = 1'b1; aluSrcIn = 1'b1; resultSrcIn = 2'b10;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [255:0] snap;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_load27();
    #12;
    chk_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Load
    step();
    chk("load_pcOut", pcOut, 32'h0000_0040);
    chk("load_aluControlOut", {29'd0, aluControlOut}, 32'd2);
    chk("load_func3Out", {29'd0, func3Out}, 32'd5);
    chk("load_func7Out", {25'd0, func7Out}, 32'h20);
    chk("load_regWriteOut", {31'd0, regWriteOut}, 32'd1);
    chk("load_validOut", {31'd0, validOut}, 32'd1);
    chk("load_misc", {immExtOut[7:0], rdOut, 1'b0, resultSrcOut, jumpOut, memReadOut, 14'd0},
        {8'hF8, 5'd9, 1'b0, 2'b10, 1'b1, 1'b1, 14'd0});
    chk("load_bubbleCount", {16'd0, bubbleCount}, 32'd0);

    // Stall three cycles with changed inputs
    snap = all_outs();
    stall = 1'b1; pcIn = 32'h0000_0080; rdIn = 5'd17; aluControlIn = 3'b111; regWriteIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      assert (all_outs() === snap) else begin
        errors++;
        $error("FAIL stall_hold_%0d: observed=%h expected=%h", i, all_outs(), snap);
      end
    end
    stall = 1'b0;
    step();
    chk("unstall_pcOut", pcOut, 32'h0000_0080);
    chk("unstall_rdOut", {27'd0, rdOut}, 32'd17);
    chk("unstall_regWriteOut", {31'd0, regWriteOut}, 32'd0);

    // Flush together with stall
    stall = 1'b1; flush = 1'b1; regWriteIn = 1'b1; memWriteIn = 1'b1;
    step();
    chk("flush_validOut", {31'd0, validOut}, 32'd0);
    chk("flush_ctrl", {27'd0, regWriteOut, memWriteOut, memReadOut, branchOut, jumpOut}, 32'd0);
    chk("flush_pcOut", pcOut, 32'd0);
    chk("flush_bubbleCount", {16'd0, bubbleCount}, 32'd1);
    stall = 1'b0; flush = 1'b0;

    // Invalid input acts as a bubble
    inValid = 1'b0; memWriteIn = 1'b1; rdIn = 5'd7;
    step();
    chk("invalid_validOut", {31'd0, validOut}, 32'd0);
    chk("invalid_memWriteOut", {31'd0, memWriteOut}, 32'd0);
    chk("invalid_rdOut", {27'd0, rdOut}, 32'd0);
    chk("invalid_bubbleCount", {16'd0, bubbleCount}, 32'd2);

    // Three more flushes, then a valid load: validOut=1, bubbleCount=5
    flush = 1'b1;
    for (int i = 0; i < 3; i++) step();
    flush = 1'b0;
    set_load27();
    step();
    chk("pre_reset_validOut", {31'd0, validOut}, 32'd1);
    chk("pre_reset_bubbleCount", {16'd0, bubbleCount}, 32'd5);

    // Asynchronous reset mid-cycle, asserted during a stall+flush
    stall = 1'b1; flush = 1'b1;
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    set_load27();
    step();
    chk("post_reset_pcOut", pcOut, 32'h0000_0040);
    chk("post_reset_validOut", {31'd0, validOut}, 32'd1);
    chk("post_reset_bubbleCount", {16'd0, bubbleCount}, 32'd0);

    // Saturation: 65540 consecutive flushes from a count of zero
    flush = 1'b1;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    @(negedge clk);
    chk("sat_fffe", {16'd0, bubbleCount}, 32'h0000_FFFE);
    step();
    chk("sat_ffff", {16'd0, bubbleCount}, 32'h0000_FFFF);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", {16'd0, bubbleCount}, 32'h0000_FFFF);
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hold current contents (hazard unit).
REQ-005 flush  input  1  replace next contents with a bubble (branch/jump redirect, load-use).
REQ-006 inValid  input  1  decode stage presents a real instruction.
REQ-007 pcIn, pcPlus4In, readData1In, readData2In, immExtIn  input  32 each  decode datapath fields.
REQ-008 rs1In, rs2In, rdIn  input  5 each  register indices.
REQ-009 func3In  input  3; func7In  input  7  instruction function fields.
REQ-010 aluControlIn  input  3  instruction-class code consumed by the downstream ALU-control decoder.
REQ-011 regWriteIn, memWriteIn, memReadIn, branchIn, jumpIn, aluSrcIn  input  1 each; resultSrcIn  input  2  control bits.
REQ-012 Each input above SHALL have a registered output of identical width named with suffix Out in place of In, plus validOut  output  1.
REQ-013 bubbleCount  output  16  number of bubbles inserted since reset.

Function
REQ-014 Update priority each rising edge SHALL be: reset > flush > stall > load.
REQ-015 Load (no flush, no stall): every Out register SHALL take its In value one cycle later; validOut SHALL take inValid.
REQ-016 Stall (no flush): every Out register, including validOut, SHALL hold its value; bubbleCount SHALL hold.
REQ-017 Flush (regardless of stall): validOut, regWriteOut, memWriteOut, memReadOut, branchOut, jumpOut SHALL become 0; all other Out registers SHALL become 0.
REQ-018 Load with inValid=0 SHALL be treated as a bubble: identical result to REQ-017.
REQ-019 bubbleCount SHALL increment by 1 on every edge where REQ-017 or REQ-018 applies, and SHALL saturate at 16'hFFFF (no wrap).
REQ-020 Whenever validOut=0, regWriteOut, memWriteOut, memReadOut, branchOut, jumpOut SHALL be 0 (no architectural side effect from a bubble).
REQ-021 Latency In to Out SHALL be exactly 1 cycle; no combinational path from any input to any output.
REQ-022 Simultaneous stall and flush SHALL insert a bubble (flush wins) and increment bubbleCount.
REQ-023 Data fields (pc, readData, imm, indices, func3/func7, aluControl) SHALL pass unmodified; no decoding inside this block.

Reset
REQ-024 Assertion of reset SHALL immediately (without clock) drive every Out register, validOut and bubbleCount to 0.
REQ-025 Reset asserted mid-stall or mid-flush SHALL override both; first edge after deassertion follows REQ-014 normally.
REQ-026 Reset SHALL NOT count as a bubble.

Verification
REQ-027 Load: inValid=1, pcIn=32'h0000_0040, aluControlIn=3'b010, func3In=3'b101, func7In=7'b0100000, regWriteIn=1 -> next edge pcOut=32'h40, aluControlOut=3'b010, func3Out=3'b101, func7Out=7'h20, regWriteOut=1, validOut=1.
REQ-028 Stall: after REQ-027 load, stall=1 for 3 cycles with changed inputs -> all Outs unchanged for 3 cycles; bubbleCount unchanged; stall=0 -> new inputs appear next edge.
REQ-029 Flush with stall: stall=1, flush=1, regWriteIn=1, memWriteIn=1 -> next edge validOut=0, regWriteOut=0, memWriteOut=0, pcOut=0, bubbleCount+1.
REQ-030 Invalid input: inValid=0, memWriteIn=1, rdIn=5'd7 -> validOut=0, memWriteOut=0, rdOut=0, bubbleCount+1.
REQ-031 Saturation: force 65,540 consecutive flush cycles -> bubbleCount reaches 16'hFFFF and stays.
REQ-032 Async reset: assert reset between clock edges with validOut=1, bubbleCount=5 -> all outputs 0 before next edge; deassert, load -> normal REQ-027 behaviour.
